// File: rtl/pe_tx_engine_if.sv
// pe_tx_engine_if: packet bus between the tx engine and the local router port
// Signals:
//   data_out  [31:0] engine -> router packet
//   valid_out        engine -> router packet valid
//   ready_in         router -> engine accepts data_out
//   data_r2p  [31:0] router -> engine packet
//   valid_r2p        router -> engine packet valid
// Modports: master = engine side, slave = router side.
interface pe_tx_engine_if;
  logic [31:0] data_out;
  logic [31:0] data_r2p;
  logic        valid_out;
  logic        ready_in;
  logic        valid_r2p;
  modport master (output data_out, valid_out, input ready_in, data_r2p, valid_r2p);
  modport slave (input data_out, valid_out, output ready_in, data_r2p, valid_r2p);
endinterface

// File: rtl/pe_tx_engine.sv
// pe_tx_engine: source-side packet engine sending sequenced packets and servicing retrans requests
// Ports:
//   clk, rst_n             clock, async active-low reset
//   enable                 gates launch of new packets
//   dbg_mode               1: last seq 255, 0: last seq 65535
//   start                  pulse, begins a task from IDLE
//   time_stamp [7:0]       TIME field at packet load
//   bus                    router bus (master side of pe_tx_engine_if)
//   task_send_finish_flag  all normal packets transferred
//   rtx_pending [2:0]      retrans FIFO occupancy
//   drop_cnt [7:0]         discarded requests, saturating
// Packet: [2:0] dst, [5:3] src, [7:6] type, [15:8] time, [31:16] seq.
module pe_tx_engine #(
  parameter logic [2:0] MY_ID = 3'b000,
  parameter logic [2:0] TAR_ID = 3'b001,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 dbg_mode,
  input  logic                 start,
  input  logic [7:0]           time_stamp,
  pe_tx_engine_if.master       bus,
  output logic                 task_send_finish_flag,
  output logic [2:0]           rtx_pending,
  output logic [7:0]           drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, HOLD, DONE} state_t;
  state_t        state;
  logic [16:0]   next_seq;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [12:0]   last_key;
  logic          req_hit, push, pop, more, has_rtx;
  logic [15:0]   req_seq, tx_seq;
  assign req_seq = bus.data_r2p[31:16];
  // {time,type,src} sits contiguously in [15:3]; it is the duplicate-filter key
  assign req_hit = bus.valid_r2p && bus.data_r2p[7:6] == 2'b10 && bus.data_r2p[2:0] == MY_ID &&
                   bus.data_r2p[5:3] == TAR_ID && bus.data_r2p[15:3] != last_key;
  assign has_rtx = cnt != '0;
  assign pop = state == SEND && enable && has_rtx;
  // a pop in the same cycle frees a slot for a push into a full FIFO
  assign push = req_hit && {1'b0, req_seq} < next_seq && (cnt != FULL || pop);
  assign more = next_seq <= (dbg_mode ? 17'd255 : 17'd65535);
  assign tx_seq = has_rtx ? mem[rd_ptr] : next_seq[15:0];
  assign rtx_pending = 3'(cnt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      last_key <= '0;
      drop_cnt <= '0;
    end else begin
      if (req_hit) last_key <= bus.data_r2p[15:3];
      if (req_hit && !push && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= req_seq;
  // HOLD always returns through SEND, so the finish decision is made in one place
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      next_seq <= '0;
      bus.data_out <= '0;
      bus.valid_out <= 1'b0;
      task_send_finish_flag <= 1'b0;
    end else
      case (state)
        IDLE: if (start && enable) state <= SEND;
        SEND:
          if (enable) begin
            if (has_rtx || more) begin
              bus.data_out <= {tx_seq, time_stamp, has_rtx ? 2'b11 : 2'b01, MY_ID, TAR_ID};
              bus.valid_out <= 1'b1;
              next_seq <= next_seq + 17'(!has_rtx);
              state <= HOLD;
            end else begin
              task_send_finish_flag <= 1'b1;
              state <= DONE;
            end
          end
        HOLD:
          if (bus.ready_in) begin
            bus.valid_out <= 1'b0;
            state <= SEND;
          end
        default: if (has_rtx && enable) state <= SEND;
      endcase
endmodule

// File: tb/tb_pe_tx_engine.sv
// tb_pe_tx_engine: directed scoreboard bench for pe_tx_engine
module tb_pe_tx_engine;
  localparam logic [2:0] MY = 3'b000;
  localparam logic [2:0] TAR = 3'b001;
  localparam logic [7:0] TS = 8'h5A;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic dbg_mode = 1'b1;
  logic start = 1'b0;
  logic [7:0] time_stamp = TS;
  logic task_send_finish_flag;
  logic [2:0] rtx_pending;
  logic [7:0] drop_cnt;
  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  pe_tx_engine_if bus();
  pe_tx_engine #(.MY_ID(MY), .TAR_ID(TAR), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dbg_mode(dbg_mode), .start(start),
    .time_stamp(time_stamp), .bus(bus), .task_send_finish_flag(task_send_finish_flag),
    .rtx_pending(rtx_pending), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;

  function automatic logic [31:0] norm(input int s);
    return {16'(s), TS, 2'b01, MY, TAR};
  endfunction
  function automatic logic [31:0] rtx(input int s);
    return {16'(s), TS, 2'b11, MY, TAR};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pkt(input string tag, input logic [31:0] pkt, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      if (bus.valid_out && bus.data_out === pkt) break;
      step;
    end
    chk(tag, 32'(i < max), 32'd1);
  endtask

  task automatic send_req(input int s, input logic [7:0] t, input logic [2:0] dst);
    bus.data_r2p = {16'(s), t, 2'b10, TAR, dst};
    bus.valid_r2p = 1'b1;
    step;
    bus.valid_r2p = 1'b0;
  endtask

  // every completed transfer must match the oldest expected packet
  always @(negedge clk)
    if (rst_n && bus.valid_out && bus.ready_in)
      chk("pkt", bus.data_out, sb.size() != 0 ? sb.pop_front() : 32'hxxxxxxxx);

  initial begin
    bus.ready_in = 1'b1;
    bus.valid_r2p = 1'b0;
    bus.data_r2p = '0;
    repeat (2) step;
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_flag", 32'(task_send_finish_flag), 32'd0);
    chk("rst_pending", 32'(rtx_pending), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    for (int s = 0; s <= 10; s++) sb.push_back(norm(s));
    step;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("launch_t1", 32'(bus.valid_out), 32'd0);
    step;
    chk("launch_t2", 32'(bus.valid_out), 32'd1);
    chk("launch_pkt", bus.data_out, norm(0));
    wait_pkt("reach7", norm(7), 40);
    bus.ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("stall_data", bus.data_out, norm(7));
      chk("stall_valid", 32'(bus.valid_out), 32'd1);
    end
    bus.ready_in = 1'b1;
    wait_pkt("reach10", norm(10), 40);
    enable = 1'b0;
    repeat (3) step;
    chk("gated_valid", 32'(bus.valid_out), 32'd0);
    send_req(3, 8'h11, MY);
    send_req(3, 8'h11, MY);
    send_req(10, 8'h12, MY);
    send_req(11, 8'h13, MY);
    step;
    chk("dup_pending", 32'(rtx_pending), 32'd2);
    chk("dup_drop", 32'(drop_cnt), 32'd1);
    chk("gated_valid2", 32'(bus.valid_out), 32'd0);
    sb.push_back(rtx(3));
    sb.push_back(rtx(10));
    for (int s = 11; s <= 20; s++) sb.push_back(norm(s));
    enable = 1'b1;
    wait_pkt("reach20", norm(20), 60);
    bus.ready_in = 1'b0;
    send_req(1, 8'h21, MY);
    send_req(2, 8'h22, MY);
    send_req(4, 8'h23, MY);
    send_req(5, 8'h24, MY);
    send_req(6, 8'h25, MY);
    send_req(9, 8'h26, MY);
    chk("full_pending", 32'(rtx_pending), 32'd4);
    chk("full_drop", 32'(drop_cnt), 32'd3);
    send_req(200, 8'h30, MY);
    chk("future_drop", 32'(drop_cnt), 32'd4);
    send_req(7, 8'h31, 3'b010);
    chk("wrong_dst", 32'(drop_cnt), 32'd4);
    chk("held_pkt", bus.data_out, norm(20));
    sb.push_back(rtx(1));
    sb.push_back(rtx(2));
    sb.push_back(rtx(4));
    sb.push_back(rtx(5));
    for (int s = 21; s <= 255; s++) sb.push_back(norm(s));
    bus.ready_in = 1'b1;
    wait_pkt("reach255", norm(255), 2000);
    step;
    chk("flag_t1", 32'(task_send_finish_flag), 32'd0);
    step;
    chk("flag_t2", 32'(task_send_finish_flag), 32'd1);
    chk("done_valid", 32'(bus.valid_out), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.push_back(rtx(100));
    send_req(100, 8'h40, MY);
    wait_pkt("done_rtx", rtx(100), 10);
    repeat (3) step;
    chk("flag_sticky", 32'(task_send_finish_flag), 32'd1);
    chk("sb_drained2", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("rst2_flag", 32'(task_send_finish_flag), 32'd0);
    for (int s = 0; s <= 2; s++) sb.push_back(norm(s));
    start = 1'b1;
    step;
    start = 1'b0;
    wait_pkt("reach2", norm(2), 20);
    bus.ready_in = 1'b0;
    step;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.valid_out), 32'd0);
    chk("async_data", bus.data_out, 32'd0);
    chk("async_pending", 32'(rtx_pending), 32'd0);
    chk("async_drop", 32'(drop_cnt), 32'd0);
    sb.delete();
    step;
    rst_n = 1'b1;
    bus.ready_in = 1'b1;
    sb.push_back(norm(0));
    start = 1'b1;
    step;
    start = 1'b0;
    wait_pkt("restart0", norm(0), 10);
    step;
    chk("sb_final", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
